// File: rtl/adc_rng_vn_packer_pkg.sv
// adc_rng_vn_packer_pkg: shared parameters and state type for the RNG debias/packing path
package adc_rng_vn_packer_pkg;
  localparam int ADC_FIF0_DEPTH = 10;
  localparam int RNG_OUT_WIDTH = 32;
  localparam int RNG_REP_LIMIT = 8;
  typedef enum logic [1:0] {IDLE, PROC, EMIT, FAIL} vn_state_t;
endpackage

// File: rtl/adc_rng_vn_packer_rep.sv
// rng_rep_count_test: repetition-count health test over successive captured vectors
module rng_rep_count_test #(
  parameter int WIDTH = 10,
  parameter int REP_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] vec,
  output logic             trip
);
  localparam int RW = $clog2(REP_LIMIT + 1);
  logic [WIDTH-1:0] prev_vec;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic seen;
  // Run length the current vector would produce; saturates at the limit
  always_comb rep_nxt = (seen && vec == prev_vec) ? ((rep_cnt == RW'(REP_LIMIT)) ? rep_cnt : rep_cnt + RW'(1)) : RW'(1);
  assign trip = cap && rep_nxt == RW'(REP_LIMIT);
  // Remember the last captured vector and its run length
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vec <= '0;
      rep_cnt <= '0;
      seen <= 1'b0;
    end else if (cap) begin
      prev_vec <= vec;
      rep_cnt <= rep_nxt;
      seen <= 1'b1;
    end
  end
endmodule

// File: rtl/adc_rng_vn_packer.sv
// adc_rng_vn_packer: drains raw FIFO vectors, von Neumann debiases them and packs words LSB-first
module adc_rng_vn_packer
  import adc_rng_vn_packer_pkg::*;
#(
  parameter int IN_WIDTH = ADC_FIF0_DEPTH,
  parameter int OUT_WIDTH = RNG_OUT_WIDTH,
  parameter int REP_LIMIT = RNG_REP_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_full,
  input  logic [IN_WIDTH-1:0]  fifo_vector,
  output logic                 fifo_deque,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 health_fail
);
  localparam int NP = IN_WIDTH / 2;
  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  vn_state_t state, state_n;
  logic [IN_WIDTH-1:0] vec_r;
  logic [OUT_WIDTH-1:0] acc, word;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [1:0] pair;
  logic more_r, trip, emit, last, full_word;
  assign pair = 2'(vec_r >> {idx, 1'b0});
  assign emit = pair[0] ^ pair[1];
  assign last = idx == IW'(NP - 1);
  assign full_word = emit && cnt == CW'(OUT_WIDTH - 1);
  assign word = acc | (OUT_WIDTH'(pair[0]) << cnt);
  assign fifo_deque = state == IDLE && fifo_full;
  rng_rep_count_test #(.WIDTH(IN_WIDTH), .REP_LIMIT(REP_LIMIT)) u_rep (
    .clk  (clk),
    .rst  (rst),
    .cap  (fifo_deque),
    .vec  (fifo_vector),
    .trip (trip)
  );
  // State register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // Next state: capture, walk pairs, hold a full word until accepted, or stop on a health trip
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = fifo_full ? (trip ? FAIL : PROC) : IDLE;
      PROC: state_n = full_word ? EMIT : (last ? IDLE : PROC);
      EMIT: state_n = out_ready ? (more_r ? PROC : IDLE) : EMIT;
      FAIL: state_n = FAIL;
    endcase
  end
  // Datapath: latch vectors, accumulate surviving bits, publish words
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r <= '0;
      acc <= '0;
      cnt <= '0;
      idx <= '0;
      more_r <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      health_fail <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (fifo_full) begin
          vec_r <= fifo_vector;
          idx <= '0;
          if (trip) begin
            acc <= '0;
            cnt <= '0;
            health_fail <= 1'b1;
          end
        end
        PROC: begin
          idx <= idx + IW'(1);
          more_r <= !last;
          if (full_word) begin
            out_data <= word;
            out_valid <= 1'b1;
            acc <= '0;
            cnt <= '0;
          end else if (emit) begin
            acc <= word;
            cnt <= cnt + CW'(1);
          end
        end
        EMIT: if (out_ready) out_valid <= 1'b0;
        FAIL: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_rng_vn_packer.sv
// tb_adc_rng_vn_packer: randomized and directed checks against a bit-queue reference model
module tb_adc_rng_vn_packer;
  import adc_rng_vn_packer_pkg::*;
  localparam int IW = 10;
  localparam int OW = 8;
  localparam int RL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_full = 1'b0;
  logic [IW-1:0] fifo_vector = '0;
  logic fifo_deque, out_valid, health_fail;
  logic out_ready = 1'b0;
  logic [OW-1:0] out_data;
  int total = 0;
  int bad = 0;
  bit rnd_ready = 0;
  bit bits_q[$];
  logic [OW-1:0] words_q[$];
  logic [IW-1:0] m_prev = '0;
  int m_run = 0;
  bit m_seen = 0;
  bit m_fail = 0;
  always #5 clk = ~clk;
  adc_rng_vn_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .REP_LIMIT(RL)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_full   (fifo_full),
    .fifo_vector (fifo_vector),
    .fifo_deque  (fifo_deque),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .health_fail (health_fail)
  );
  task automatic model_capture(input logic [IW-1:0] v);
    logic [OW-1:0] w;
    m_run = (m_seen && v == m_prev) ? ((m_run < RL) ? m_run + 1 : RL) : 1;
    m_prev = v;
    m_seen = 1;
    if (m_run == RL) begin
      m_fail = 1;
      bits_q.delete();
    end else begin
      for (int i = 0; i < IW / 2; i++) if (v[2*i] != v[2*i+1]) bits_q.push_back(v[2*i]);
      while (bits_q.size() >= OW) begin
        w = '0;
        for (int k = 0; k < OW; k++) w[k] = bits_q.pop_front();
        words_q.push_back(w);
      end
    end
  endtask
  always @(negedge clk) begin
    total++;
    if (health_fail !== m_fail) begin
      bad++;
      $display("FAIL health_fail: got %0b want %0b", health_fail, m_fail);
    end
    if (out_valid === 1'b1) begin
      total++;
      if (words_q.size() == 0) begin
        bad++;
        $display("FAIL out_word: got %h want no word", out_data);
      end else begin
        if (out_data !== words_q[0]) begin
          bad++;
          $display("FAIL out_word: got %h want %h", out_data, words_q[0]);
        end
        if (out_ready) void'(words_q.pop_front());
      end
    end
    if (rst) begin
      bits_q.delete();
      words_q.delete();
      m_seen = 0;
      m_run = 0;
      m_fail = 0;
    end else if (fifo_deque === 1'b1) model_capture(fifo_vector);
  end
  task automatic do_reset();
    fifo_full = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic send(input logic [IW-1:0] v);
    int n = 0;
    fifo_full = 1'b1;
    fifo_vector = v;
    while (1) begin
      @(negedge clk);
      if (fifo_deque === 1'b1 || n >= 200) break;
      n++;
      @(posedge clk);
      #1 if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    total++;
    if (fifo_deque !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout: got no dequeue want dequeue of %b", v);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    fifo_vector = IW'($urandom);
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total += 6;
    if (fifo_deque !== 1'b0) begin bad++; $display("FAIL rst_deque: got %b want 0", fifo_deque); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", out_data); end
    if (health_fail !== 1'b0) begin bad++; $display("FAIL rst_health: got %b want 0", health_fail); end
    if (dut.cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", dut.cnt); end
    if (dut.state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
  endtask
  task automatic test_single_decode();
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    send(10'b0100111001);
    fifo_full = 1'b1;
    fifo_vector = 10'b1111111111;
    while (1) begin
      @(negedge clk);
      n++;
      if (fifo_deque === 1'b1 || n >= 50) break;
    end
    total += 4;
    if (n != 6) begin bad++; $display("FAIL decode_latency: got %0d want 6", n); end
    if (dut.cnt !== 3) begin bad++; $display("FAIL decode_cnt: got %0d want 3", dut.cnt); end
    if (dut.acc[2:0] !== 3'b101) begin bad++; $display("FAIL decode_acc: got %b want 101", dut.acc[2:0]); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL decode_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1 fifo_full = 1'b0;
  endtask
  task automatic test_stall();
    int n = 0;
    do_reset();
    out_ready = 1'b0;
    send(10'b0101010101);
    send(10'b1010101010);
    fifo_full = 1'b1;
    fifo_vector = 10'b1100110011;
    while (1) begin
      @(negedge clk);
      if (out_valid === 1'b1 || n >= 50) break;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", out_valid); end
      if (out_data !== 8'h1F) begin bad++; $display("FAIL stall_data: got %h want 1f", out_data); end
      if (fifo_deque !== 1'b0) begin bad++; $display("FAIL stall_deque: got %b want 0", fifo_deque); end
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (fifo_deque === 1'b1 || n >= 50) break;
    end
    total += 2;
    if (n != 3) begin bad++; $display("FAIL stall_resume: got %0d want 3", n); end
    if (dut.cnt !== 2) begin bad++; $display("FAIL stall_carry_cnt: got %0d want 2", dut.cnt); end
    @(posedge clk);
    #1 fifo_full = 1'b0;
  endtask
  task automatic test_all_equal();
    send(10'b0000000000);
    repeat (6) @(negedge clk);
    total += 2;
    if (dut.cnt !== 2) begin bad++; $display("FAIL equal_cnt: got %0d want 2", dut.cnt); end
    if (dut.u_rep.rep_cnt !== 1) begin bad++; $display("FAIL equal_rep: got %0d want 1", dut.u_rep.rep_cnt); end
  endtask
  task automatic test_repetition();
    logic [IW-1:0] v;
    do_reset();
    out_ready = 1'b1;
    v = IW'($urandom);
    repeat (RL) send(v);
    @(negedge clk);
    total += 2;
    if (health_fail !== 1'b1) begin bad++; $display("FAIL rep_trip: got %b want 1", health_fail); end
    if (dut.cnt !== '0) begin bad++; $display("FAIL rep_discard: got %0d want 0", dut.cnt); end
    fifo_full = 1'b1;
    repeat (10) begin
      @(negedge clk);
      total += 2;
      if (fifo_deque !== 1'b0) begin bad++; $display("FAIL rep_deque: got %b want 0", fifo_deque); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rep_valid: got %b want 0", out_valid); end
    end
    do_reset();
    @(negedge clk);
    total++;
    if (health_fail !== 1'b0) begin bad++; $display("FAIL rep_clear: got %b want 0", health_fail); end
  endtask
  task automatic test_reset_emit();
    int n = 0;
    do_reset();
    out_ready = 1'b0;
    send(10'b0101010101);
    send(10'b0101010101);
    while (1) begin
      @(negedge clk);
      if (out_valid === 1'b1 || n >= 50) break;
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL emit_reach: got %b want 1", out_valid); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL emit_rst_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL emit_rst_data: got %h want 0", out_data); end
    if (dut.cnt !== '0) begin bad++; $display("FAIL emit_rst_cnt: got %0d want 0", dut.cnt); end
    if (dut.state !== IDLE) begin bad++; $display("FAIL emit_rst_state: got %0d want IDLE", dut.state); end
  endtask
  task automatic test_zero_stall();
    int n = 0;
    int v_cnt = 0;
    do_reset();
    out_ready = 1'b1;
    send(10'b0101010101);
    send(10'b0101010101);
    fifo_full = 1'b1;
    fifo_vector = 10'b1100110011;
    while (1) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) v_cnt++;
      if (fifo_deque === 1'b1 || n >= 50) break;
    end
    total += 3;
    if (v_cnt != 1) begin bad++; $display("FAIL zs_valid_cycles: got %0d want 1", v_cnt); end
    if (n != 7) begin bad++; $display("FAIL zs_latency: got %0d want 7", n); end
    if (dut.cnt !== 2) begin bad++; $display("FAIL zs_cnt: got %0d want 2", dut.cnt); end
    @(posedge clk);
    #1 fifo_full = 1'b0;
  endtask
  task automatic test_random();
    logic [IW-1:0] v, prev;
    do_reset();
    prev = '0;
    rnd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      do v = IW'($urandom); while (v == prev);
      prev = v;
      send(v);
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (words_q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending want 0", words_q.size()); end
  endtask
  initial begin
    test_reset();
    test_single_decode();
    test_stall();
    test_all_equal();
    test_repetition();
    test_reset_emit();
    test_zero_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adc_rng_vn_packer.md
# adc_rng_vn_packer

Downstream consumer of the ADC RNG bit FIFO. It drains each full raw vector through the FIFO's dequeue interface and runs a repetition-count health test on every captured vector. It applies a von Neumann debiaser to the vector's bit pairs and packs the surviving bits LSB-first into fixed-width words. Those words are offered to the conditioning/output stage over a valid/ready handshake.

## Interface
Parameters:
- IN_WIDTH, default ADC_FIF0_DEPTH (10): raw vector width; must be even.
- OUT_WIDTH, default RNG_OUT_WIDTH (32): packed output word width.
- REP_LIMIT, default RNG_REP_LIMIT (8): consecutive identical vectors that trip the health test; must be ≥2.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fifo_full  in  1  FIFO holds a complete vector.
- fifo_vector  in  IN_WIDTH  FIFO read data; valid only in the cycle fifo_deque=1. Bit 0 is the oldest bit.
- fifo_deque  out  1  one-cycle dequeue strobe.
- out_valid  out  1  out_data holds a complete word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_WIDTH  packed debiased word; first emitted bit is in bit 0.
- health_fail  out  1  sticky repetition-test failure.

## Operation
- States: IDLE, PROC, EMIT, FAIL.
- **IDLE**
  - If fifo_full=1, assert fifo_deque combinationally this cycle and latch fifo_vector into vec_r.
  - Run the health test on the captured vector (below).
  - If the test passes: pair index := 0, go to PROC.
  - If it trips: go to FAIL.
- **PROC**
  - Each cycle processes pair i: a = vec_r[2i], b = vec_r[2i+1].
  - If a≠b, emit bit a into acc[cnt] and increment cnt. If a=b, discard.
  - Then i := i+1.
  - If the emit makes cnt reach OUT_WIDTH: load out_data with the full word, set out_valid, clear acc/cnt, go to EMIT.
  - Otherwise, after pair IN_WIDTH/2−1, go to IDLE.
- **EMIT**
  - out_valid=1 and out_data are held stable.
  - On out_ready=1: clear out_valid. Return to PROC if pairs remain, else to IDLE.
  - No dequeue in EMIT, even with fifo_full=1.
- **Health test**
  - The first capture after reset sets rep_cnt=1.
  - Each later capture compares against prev_vec: equal → rep_cnt+1; different → rep_cnt=1.
  - prev_vec := captured vector.
  - When rep_cnt reaches REP_LIMIT: health_fail=1, the tripping vector is not processed, and the partial acc is discarded.
- **FAIL**: terminal until rst. fifo_deque=0, out_valid=0.
- **Widths**
  - cnt is $clog2(OUT_WIDTH+1) bits.
  - Pair index is $clog2(IN_WIDTH/2) bits, minimum 1.
  - rep_cnt saturates at REP_LIMIT.
- A partial word persists across vectors. It is never flushed except by rst.

## Timing
- Reset values:
  - fifo_deque=0, out_valid=0, out_data=0, health_fail=0.
  - State IDLE; acc, cnt, pair index, rep_cnt, prev_vec and vec_r all 0.
- Capture to first pair processed: 1 cycle. Full vector without stall: 1 + IN_WIDTH/2 cycles.
- out_valid rises the cycle after the pair that completes the word.
  - Earliest out_ready handshake is that same cycle.
  - Processing resumes the cycle after the handshake.
- health_fail rises the cycle after the tripping capture.
- rst mid-operation, including during EMIT, returns every output to its reset value on the next edge and drops the pending word.

## Structure
- Add to package params:
  - RNG_OUT_WIDTH and RNG_REP_LIMIT.
  - typedef enum logic [1:0] vn_state_t {IDLE, PROC, EMIT, FAIL}.
- One sub-module: rng_rep_count_test.
  - Holds prev_vec, rep_cnt and the first-capture flag.
  - Inputs: clk, rst, cap strobe, vector. Output: trip.

## Test plan
Defaults unless stated (IN_WIDTH=10).
1. Single decode, OUT_WIDTH=32, out_ready=1: vector 10'b0100111001 (pairs 10,01,11,00,10) → bits 1,0,1 emitted; cnt=3, acc[2:0]=3'b101, no out_valid; fifo_deque high exactly 1 cycle; back in IDLE 6 cycles after capture.
2. Packing with stall, OUT_WIDTH=8:
   - Stimulus: 10'b0101010101 (five 1s), then 10'b1010101010 (five 0s), out_ready=0 for 5 cycles.
   - Response: out_data=8'h1F; out_valid and out_data stable while stalled; fifo_deque=0 despite fifo_full=1.
   - After the handshake, cnt=2 with 2'b00 carried into the next word.
3. All-equal pairs: 10'b0000000000 after a distinct vector → no bits emitted, cnt unchanged, rep_cnt=1.
4. Repetition, REP_LIMIT=4:
   - Stimulus: same vector captured 4 times.
   - Response: health_fail=1 the cycle after the 4th capture; the 4th vector is not processed.
   - Afterwards fifo_deque stays 0 with fifo_full=1 and out_valid stays 0 until rst. After rst, health_fail=0.
5. Reset in EMIT: rst pulsed while out_valid=1 → next cycle out_valid=0, out_data=0, cnt=0, state IDLE.
6. Zero-stall handshake, OUT_WIDTH=8: out_ready held 1 → out_valid high exactly 1 cycle per word; the remaining pair of the vector is processed the following cycle.
